// File: rtl/dm_sba_ctrl_pkg.sv
// Shared types for the debug-module system bus access engine: FSM states and sbcs.sberror codes.
package dm_sba_ctrl_pkg;

   typedef enum logic [2:0] {
      Idle,
      Read,
      Write,
      WaitRead,
      WaitWrite
   } sba_state_t;

   localparam logic [2:0] SbErrNone    = 3'd0;
   localparam logic [2:0] SbErrTimeout = 3'd1;
   localparam logic [2:0] SbErrBadAddr = 3'd2;
   localparam logic [2:0] SbErrAlign   = 3'd3;
   localparam logic [2:0] SbErrSize    = 3'd4;
   localparam logic [2:0] SbErrOther   = 3'd7;

endpackage

// File: rtl/dm_sba_lane.sv
// Byte-lane steering between right-aligned sbdata and the BusWidth-wide bus:
// byte enables, write-data shift and read-data extraction with size masking.
module dm_sba_lane #(
   parameter int unsigned BusWidth = 64
) (
   input  logic [$clog2(BusWidth/8)-1:0] off,
   input  logic [2:0]                    size,
   input  logic [BusWidth-1:0]           wdata,
   input  logic [BusWidth-1:0]           rdata,
   output logic [BusWidth/8-1:0]         be,
   output logic [BusWidth-1:0]           wdata_sh,
   output logic [BusWidth-1:0]           rdata_al
);
   localparam int unsigned BE = BusWidth / 8;

   logic [15:0] be_raw;

   // Oversized accesses saturate to all-ones here; the controller rejects them before use.
   assign be_raw   = (16'd1 << (16'd1 << size)) - 16'd1;
   assign be       = BE'(be_raw) << off;
   assign wdata_sh = wdata << {off, 3'b000};
   assign rdata_al = (rdata >> {off, 3'b000}) & ~({BusWidth{1'b1}} << (32'd8 << size));

endmodule

// File: rtl/dm_sba_ctrl.sv
// System bus access engine: turns sbcs/sbaddress/sbdata events into single bus transfers
// with size/alignment pre-checks, response timeout and sticky error reporting.
//
// state     | meaning
// Idle      | no access in flight, accepts triggers
// Read      | read request driven, waiting for gnt_i
// Write     | write request driven, waiting for gnt_i
// WaitRead  | read granted, waiting for r_valid_i
// WaitWrite | write granted, waiting for r_valid_i
module dm_sba_ctrl
   import dm_sba_ctrl_pkg::*;
#(
   parameter int unsigned BusWidth      = 64,
   parameter int unsigned TimeoutCycles = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [63:0]           sbaddress_i,
   input  logic                  sbaddress_write_i,
   input  logic [BusWidth-1:0]   sbdata_i,
   input  logic                  sbdata_write_i,
   input  logic                  sbdata_read_i,
   input  logic [2:0]            sbaccess_i,
   input  logic                  sbreadonaddr_i,
   input  logic                  sbautoincrement_i,
   input  logic                  sbreadondata_i,
   input  logic                  sberror_clear_i,
   output logic [63:0]           sbaddress_o,
   output logic [BusWidth-1:0]   sbdata_o,
   output logic                  sbdata_valid_o,
   output logic                  sbbusy_o,
   output logic                  sbbusyerror_o,
   output logic [2:0]            sberror_o,
   output logic                  req_o,
   output logic                  we_o,
   output logic [63:0]           add_o,
   output logic [BusWidth-1:0]   wdata_o,
   output logic [BusWidth/8-1:0] be_o,
   input  logic                  gnt_i,
   input  logic                  r_valid_i,
   input  logic                  r_err_i,
   input  logic [BusWidth-1:0]   r_rdata_i
);
   localparam int unsigned BE = BusWidth / 8;
   localparam int unsigned OW = $clog2(BE);
   localparam int unsigned TW = $clog2(TimeoutCycles + 2);

   sba_state_t        state;
   logic [TW-1:0]     tmo_cnt;
   logic [OW-1:0]     acc_off;
   logic [2:0]        acc_size;
   logic [63:0]       addr_eff;
   logic              trig_wr, trig_rd, trig_any;
   logic              size_bad, align_bad, tmo_hit;
   logic [OW-1:0]     lane_off;
   logic [2:0]        lane_size;
   logic [BE-1:0]     lane_be;
   logic [BusWidth-1:0] lane_wdata, lane_rdata;

   // A readonaddr trigger must use the address being written in the same cycle.
   always_comb begin
      addr_eff  = sbaddress_write_i ? sbaddress_i : sbaddress_o;
      trig_wr   = sbdata_write_i;
      trig_rd   = (sbaddress_write_i & sbreadonaddr_i) | (sbdata_read_i & sbreadondata_i);
      trig_any  = trig_wr | trig_rd;
      size_bad  = (32'd8 << sbaccess_i) > BusWidth;
      align_bad = (addr_eff & ~(64'hFFFF_FFFF_FFFF_FFFF << sbaccess_i)) != 64'd0;
      lane_off  = (state == Idle) ? addr_eff[OW-1:0] : acc_off;
      lane_size = (state == Idle) ? sbaccess_i : acc_size;
      tmo_hit   = (TimeoutCycles != 0) && (tmo_cnt == TW'(1));
   end

   assign sbbusy_o = (state != Idle);

   dm_sba_lane #(.BusWidth(BusWidth)) u_lane (
      .off      (lane_off),
      .size     (lane_size),
      .wdata    (sbdata_i),
      .rdata    (r_rdata_i),
      .be       (lane_be),
      .wdata_sh (lane_wdata),
      .rdata_al (lane_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= Idle;
         req_o          <= 1'b0;
         we_o           <= 1'b0;
         sbdata_valid_o <= 1'b0;
         sbbusyerror_o  <= 1'b0;
         sberror_o      <= SbErrNone;
         sbaddress_o    <= 64'd0;
         sbdata_o       <= '0;
         be_o           <= '0;
         add_o          <= 64'd0;
         wdata_o        <= '0;
         acc_off        <= '0;
         acc_size       <= 3'd0;
         tmo_cnt        <= '0;
      end else begin
         sbdata_valid_o <= 1'b0;
         sbbusyerror_o  <= 1'b0;
         // Error assignments below come later and therefore beat a coincident clear.
         if (sberror_clear_i) sberror_o <= SbErrNone;
         if (sbaddress_write_i) sbaddress_o <= sbaddress_i;
         if (state != Idle && TimeoutCycles != 0) tmo_cnt <= tmo_cnt - TW'(1);

         case (state)
            Idle: begin
               if (trig_any && sberror_o == SbErrNone) begin
                  if (size_bad) begin
                     sberror_o <= SbErrSize;
                  end else if (align_bad) begin
                     sberror_o <= SbErrAlign;
                  end else begin
                     req_o    <= 1'b1;
                     we_o     <= trig_wr;
                     state    <= trig_wr ? Write : Read;
                     add_o    <= addr_eff & ~64'(BE - 1);
                     be_o     <= lane_be;
                     wdata_o  <= lane_wdata;
                     acc_off  <= addr_eff[OW-1:0];
                     acc_size <= sbaccess_i;
                     tmo_cnt  <= TW'(TimeoutCycles);
                  end
               end
            end
            Read, Write: begin
               if (trig_any) sbbusyerror_o <= 1'b1;
               if (tmo_hit) begin
                  sberror_o <= SbErrTimeout;
                  req_o     <= 1'b0;
                  we_o      <= 1'b0;
                  state     <= Idle;
               end else if (gnt_i) begin
                  req_o <= 1'b0;
                  we_o  <= 1'b0;
                  state <= (state == Read) ? WaitRead : WaitWrite;
               end
            end
            WaitRead, WaitWrite: begin
               if (trig_any) sbbusyerror_o <= 1'b1;
               if (r_valid_i) begin
                  state <= Idle;
                  if (r_err_i) begin
                     sberror_o <= SbErrBadAddr;
                  end else begin
                     if (state == WaitRead) begin
                        sbdata_o       <= lane_rdata;
                        sbdata_valid_o <= 1'b1;
                     end
                     if (sbautoincrement_i && !sbaddress_write_i)
                        sbaddress_o <= sbaddress_o + (64'd1 << acc_size);
                  end
               end else if (tmo_hit) begin
                  sberror_o <= SbErrTimeout;
                  state     <= Idle;
               end
            end
            default: state <= Idle;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Directed + randomized bench for dm_sba_ctrl against a byte-level reference model.
module tb_dm_sba_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [63:0] sbaddress_i;
   logic        sbaddress_write_i;
   logic [63:0] sbdata_i;
   logic        sbdata_write_i, sbdata_read_i;
   logic [2:0]  sbaccess_i;
   logic        sbreadonaddr_i, sbautoincrement_i, sbreadondata_i, sberror_clear_i;
   logic [63:0] sbaddress_o, sbdata_o, add_o, wdata_o;
   logic        sbdata_valid_o, sbbusy_o, sbbusyerror_o, req_o, we_o;
   logic [2:0]  sberror_o;
   logic [7:0]  be_o;
   logic        gnt_i, r_valid_i, r_err_i;
   logic [63:0] r_rdata_i;

   // narrow-bus instance, own triggers, bus side idle
   logic        aw32, clr32;
   logic [63:0] sbaddress32, add32;
   logic [31:0] sbdata32, wdata32;
   logic        valid32, busy32, busyerr32, req32, we32;
   logic [2:0]  sberror32;
   logic [3:0]  be32;

   int tests = 0;
   int fails = 0;
   logic [63:0] last_rd;

   always #5 clk = ~clk;

   dm_sba_ctrl #(.BusWidth(64), .TimeoutCycles(8)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .sbaddress_i(sbaddress_i), .sbaddress_write_i(sbaddress_write_i),
      .sbdata_i(sbdata_i), .sbdata_write_i(sbdata_write_i), .sbdata_read_i(sbdata_read_i),
      .sbaccess_i(sbaccess_i), .sbreadonaddr_i(sbreadonaddr_i),
      .sbautoincrement_i(sbautoincrement_i), .sbreadondata_i(sbreadondata_i),
      .sberror_clear_i(sberror_clear_i),
      .sbaddress_o(sbaddress_o), .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o),
      .sbbusy_o(sbbusy_o), .sbbusyerror_o(sbbusyerror_o), .sberror_o(sberror_o),
      .req_o(req_o), .we_o(we_o), .add_o(add_o), .wdata_o(wdata_o), .be_o(be_o),
      .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_err_i(r_err_i), .r_rdata_i(r_rdata_i)
   );

   dm_sba_ctrl #(.BusWidth(32), .TimeoutCycles(8)) dut32 (
      .clk_i(clk), .rst_i(rst_i),
      .sbaddress_i(sbaddress_i), .sbaddress_write_i(aw32),
      .sbdata_i(sbdata_i[31:0]), .sbdata_write_i(1'b0), .sbdata_read_i(1'b0),
      .sbaccess_i(sbaccess_i), .sbreadonaddr_i(sbreadonaddr_i),
      .sbautoincrement_i(1'b0), .sbreadondata_i(1'b0),
      .sberror_clear_i(clr32),
      .sbaddress_o(sbaddress32), .sbdata_o(sbdata32), .sbdata_valid_o(valid32),
      .sbbusy_o(busy32), .sbbusyerror_o(busyerr32), .sberror_o(sberror32),
      .req_o(req32), .we_o(we32), .add_o(add32), .wdata_o(wdata32), .be_o(be32),
      .gnt_i(1'b0), .r_valid_i(1'b0), .r_err_i(1'b0), .r_rdata_i(32'd0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: byte-granular view of the bus lanes.
   function automatic logic [7:0] exp_be(input logic [63:0] a, input logic [2:0] s);
      logic [7:0] r;
      int off, n;
      r = '0;
      off = int'(a[2:0]);
      n = 1 << s;
      for (int i = 0; i < 8; i++)
         if (i >= off && i < off + n) r[i] = 1'b1;
      return r;
   endfunction

   function automatic logic [63:0] exp_wdata(input logic [63:0] a, input logic [63:0] d);
      logic [63:0] r;
      int off;
      r = '0;
      off = int'(a[2:0]);
      for (int j = 0; j < 8; j++)
         if (j >= off) r[8*j +: 8] = d[8*(j-off) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] exp_rdata(input logic [63:0] a, input logic [2:0] s,
                                             input logic [63:0] rd);
      logic [63:0] r;
      int off;
      r = '0;
      off = int'(a[2:0]);
      for (int i = 0; i < (1 << s); i++)
         r[8*i +: 8] = rd[8*(off+i) +: 8];
      return r;
   endfunction

   task automatic run_access(input bit is_wr, input logic [63:0] addr, input logic [2:0] sz,
                             input logic [63:0] wd, input logic [63:0] rd, input bit rerr,
                             input bit autoinc, input int gdly, input int rdly);
      logic [63:0] exp_addr;
      sbaccess_i = sz;
      sbautoincrement_i = autoinc;
      sbreadonaddr_i = !is_wr;
      sbaddress_i = addr;
      sbaddress_write_i = 1'b1;
      step();
      sbaddress_write_i = 1'b0;
      if (is_wr) begin
         sbdata_i = wd;
         sbdata_write_i = 1'b1;
         step();
         sbdata_write_i = 1'b0;
      end
      check("req_rise", req_o, 1);
      check("we", we_o, is_wr);
      check("add", add_o, addr & ~64'h7);
      check("be", be_o, exp_be(addr, sz));
      if (is_wr) check("wdata", wdata_o, exp_wdata(addr, wd));
      repeat (gdly) step();
      gnt_i = 1'b1;
      step();
      gnt_i = 1'b0;
      check("req_drop", req_o, 0);
      check("busy_wait", sbbusy_o, 1);
      repeat (rdly) step();
      r_valid_i = 1'b1;
      r_err_i = rerr;
      r_rdata_i = rd;
      sberror_clear_i = rerr;
      step();
      r_valid_i = 1'b0;
      r_err_i = 1'b0;
      sberror_clear_i = 1'b0;
      check("busy_done", sbbusy_o, 0);
      check("sberror", sberror_o, rerr ? 64'd2 : 64'd0);
      exp_addr = (autoinc && !rerr) ? addr + (64'd1 << sz) : addr;
      check("sbaddress", sbaddress_o, exp_addr);
      check("valid", sbdata_valid_o, (!is_wr && !rerr) ? 64'd1 : 64'd0);
      if (!is_wr && !rerr) begin
         last_rd = exp_rdata(addr, sz, rd);
         check("rdata", sbdata_o, last_rd);
      end
      step();
      check("valid_pulse", sbdata_valid_o, 0);
      if (rerr) begin
         sberror_clear_i = 1'b1;
         step();
         sberror_clear_i = 1'b0;
         check("err_clr", sberror_o, 0);
      end
      sbreadonaddr_i = 1'b0;
      sbautoincrement_i = 1'b0;
   endtask

   initial begin
      logic [63:0] a, d, rd;
      logic [2:0]  sz;
      bit          wr, er, ai;

      rst_i = 1'b1;
      sbaddress_i = '0; sbaddress_write_i = 0; sbdata_i = '0; sbdata_write_i = 0;
      sbdata_read_i = 0; sbaccess_i = 3'd2; sbreadonaddr_i = 0; sbautoincrement_i = 0;
      sbreadondata_i = 0; sberror_clear_i = 0; gnt_i = 0; r_valid_i = 0; r_err_i = 0;
      r_rdata_i = '0; aw32 = 0; clr32 = 0; last_rd = '0;
      repeat (3) step();
      rst_i = 1'b0;

      check("rst_busy", sbbusy_o, 0);
      check("rst_req", req_o, 0);
      check("rst_we", we_o, 0);
      check("rst_err", sberror_o, 0);
      check("rst_addr", sbaddress_o, 0);
      check("rst_data", sbdata_o, 0);
      check("rst_be", be_o, 0);
      check("rst_valid", sbdata_valid_o, 0);

      // 32b write 0xDEADBEEF @0x1004
      run_access(1, 64'h1004, 3'd2, 64'hDEAD_BEEF, 64'd0, 0, 0, 1, 1);
      check("wr32_be_upper", {56'd0, exp_be(64'h1004, 3'd2)}, 64'hF0);

      // 8b read on address write @0x1003
      run_access(0, 64'h1003, 3'd0, 64'd0, 64'h8877_6655_4433_2211, 0, 0, 0, 2);
      check("rd8_byte", sbdata_o, 64'h44);

      // 64b autoincrement read wrapping the address space
      run_access(0, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 1, 2, 0);
      check("wrap_addr", sbaddress_o, 64'd0);

      // misaligned 16b read
      sbreadonaddr_i = 1'b1; sbaccess_i = 3'd1;
      sbaddress_i = 64'h1001; sbaddress_write_i = 1'b1; step(); sbaddress_write_i = 1'b0;
      check("mis_err", sberror_o, 3);
      check("mis_req", req_o, 0);
      step();
      check("mis_req_later", req_o, 0);
      sbaccess_i = 3'd0;
      sbdata_write_i = 1'b1; step(); sbdata_write_i = 1'b0;
      check("err_drop_req", req_o, 0);
      check("err_drop_busy", sbbusy_o, 0);
      check("err_drop_busyerr", sbbusyerror_o, 0);
      sberror_clear_i = 1'b1; step(); sberror_clear_i = 1'b0;
      check("mis_clr", sberror_o, 0);
      sbreadonaddr_i = 1'b0;

      // timeout after grant, busy triggers during the wait
      sbaccess_i = 3'd3; sbaddress_i = 64'h3000;
      sbaddress_write_i = 1'b1; step(); sbaddress_write_i = 1'b0;
      sbdata_i = 64'h1111_2222_3333_4444; sbdata_write_i = 1'b1; step(); sbdata_write_i = 1'b0;
      check("to_req", req_o, 1);
      gnt_i = 1'b1; step(); gnt_i = 1'b0;
      step();
      sbdata_write_i = 1'b1; step(); sbdata_write_i = 1'b0;
      check("busyerr_pulse", sbbusyerror_o, 1);
      step();
      check("busyerr_clear", sbbusyerror_o, 0);
      sbreadonaddr_i = 1'b1; sbaddress_i = 64'h4000; sbaddress_write_i = 1'b1; step();
      sbaddress_write_i = 1'b0; sbreadonaddr_i = 1'b0;
      check("busy_addr_busyerr", sbbusyerror_o, 1);
      check("busy_addr_load", sbaddress_o, 64'h4000);
      step(); step();
      check("to_before", sberror_o, 0);
      check("to_before_busy", sbbusy_o, 1);
      step();
      check("to_err", sberror_o, 1);
      check("to_idle", sbbusy_o, 0);
      check("to_req_low", req_o, 0);
      r_valid_i = 1'b1; r_rdata_i = 64'hCAFE; step(); r_valid_i = 1'b0;
      check("late_valid", sbdata_valid_o, 0);
      check("late_data", sbdata_o, last_rd);
      sberror_clear_i = 1'b1; step(); sberror_clear_i = 1'b0;
      check("to_clr", sberror_o, 0);

      // narrow bus: oversize rejected, then a legal access times out without grant
      sbreadonaddr_i = 1'b1; sbaccess_i = 3'd3; sbaddress_i = 64'h2000;
      aw32 = 1'b1; step(); aw32 = 1'b0;
      check("w32_size_err", sberror32, 4);
      check("w32_size_req", req32, 0);
      clr32 = 1'b1; step(); clr32 = 1'b0;
      sbaccess_i = 3'd2; sbaddress_i = 64'h2004;
      aw32 = 1'b1; step(); aw32 = 1'b0;
      check("w32_req", req32, 1);
      check("w32_be", be32, 4'hF);
      check("w32_add", add32, 64'h2004);
      repeat (8) step();
      check("w32_timeout", sberror32, 1);
      sbreadonaddr_i = 1'b0;

      // randomized traffic
      for (int k = 0; k < 24; k++) begin
         sz = 3'($urandom_range(0, 3));
         a  = {$urandom, $urandom} & ~((64'd1 << sz) - 64'd1);
         d  = {$urandom, $urandom};
         rd = {$urandom, $urandom};
         wr = 1'($urandom_range(0, 1));
         er = ($urandom_range(0, 4) == 0);
         ai = wr ? 1'b0 : 1'($urandom_range(0, 1));
         run_access(wr, a, sz, d, rd, er, ai, $urandom_range(0, 2), $urandom_range(0, 3));
      end

      // reset while waiting for read response
      sbreadonaddr_i = 1'b1; sbaccess_i = 3'd2; sbaddress_i = 64'h5000;
      sbaddress_write_i = 1'b1; step(); sbaddress_write_i = 1'b0; sbreadonaddr_i = 1'b0;
      check("rst_mid_req", req_o, 1);
      gnt_i = 1'b1; step(); gnt_i = 1'b0;
      check("rst_mid_wait", sbbusy_o, 1);
      rst_i = 1'b1; step(); rst_i = 1'b0;
      check("rst_mid_busy", sbbusy_o, 0);
      check("rst_mid_req_low", req_o, 0);
      r_valid_i = 1'b1; r_rdata_i = 64'hFFFF_FFFF; step(); r_valid_i = 1'b0;
      check("rst_mid_valid", sbdata_valid_o, 0);
      check("rst_mid_data", sbdata_o, 0);
      check("rst_mid_idle", sbbusy_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
